// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: front-end fetch stage.
// Holds the program counter and a word-addressed instruction memory with a
// synchronous load port. The fetched word is registered into the IF/ID
// pipeline register, which feeds the instruction-decode Controller.
// Supports stall (hold everything) and branch/jump redirect (flush + PC load).
module instruction_fetch_unit #(
  parameter int          MEM_DEPTH = 128,
  parameter int          ADDR_W    = 7,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [31:0]       BranchTarget,
  input  logic              ImemWe,
  input  logic [ADDR_W-1:0] ImemWrAddr,
  input  logic [31:0]       ImemWrData,
  output logic [31:0]       PC,
  output logic [31:0]       IFID_Instruction,
  output logic [31:0]       IFID_PCPlus4,
  output logic              IFID_Valid
);

  // A bubble is the all-zero word, which decodes as a MIPS sll NOP.
  localparam logic [31:0] BUBBLE = 32'h00000000;

  logic [31:0]       instrMem [MEM_DEPTH];
  logic [ADDR_W-1:0] fetchIndex;
  logic [31:0]       fetchWord;
  logic [31:0]       pcPlus4;
  logic [31:0]       redirectPc;
  logic              unusedTargetBits;

  // Only the word-index bits of the PC select a memory word; higher bits
  // simply wrap the fetch around the memory.
  assign fetchIndex = PC[ADDR_W+1:2];
  assign fetchWord  = instrMem[fetchIndex];
  assign pcPlus4    = PC + 32'd4;

  // Redirect targets are forced word-aligned so the PC never leaves alignment.
  assign redirectPc       = {BranchTarget[31:2], 2'b00};
  assign unusedTargetBits = ^BranchTarget[1:0];

  // Instruction memory load port; deliberately independent of Reset so the
  // program can be preloaded while the pipeline is held in reset.
  always_ff @(posedge Clk) begin
    if (ImemWe) begin
      instrMem[ImemWrAddr] <= ImemWrData;
    end
  end

  // PC and IF/ID register update: reset, then redirect, then stall, then fetch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC               <= RESET_PC;
      IFID_Instruction <= BUBBLE;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (BranchTaken) begin
      PC               <= redirectPc;
      IFID_Instruction <= BUBBLE;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (Stall) begin
      PC               <= PC;
      IFID_Instruction <= IFID_Instruction;
      IFID_PCPlus4     <= IFID_PCPlus4;
      IFID_Valid       <= IFID_Valid;
    end else begin
      PC               <= pcPlus4;
      IFID_Instruction <= fetchWord;
      IFID_PCPlus4     <= pcPlus4;
      IFID_Valid       <= 1'b1;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the instruction-decode Controller.
- Holds the program counter and a word-addressed instruction memory with a synchronous load port.
- Registers the fetched word into the IF/ID pipeline register, whose Instruction output drives the Controller.
- Supports stall (hold) and branch/jump redirect (flush plus PC load).

Parameters:
MEM_DEPTH, 128, number of 32-bit instruction words; must be a power of two.
ADDR_W, 7, word-index width; equals log2(MEM_DEPTH).
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Stall  input  1  hold PC and IF/ID contents this cycle.
BranchTaken  input  1  redirect the PC to BranchTarget and flush IF/ID.
BranchTarget  input  32  redirect address; bits [1:0] are ignored.
ImemWe  input  1  instruction-memory write enable.
ImemWrAddr  input  ADDR_W  word index to write.
ImemWrData  input  32  word to write.
PC  output  32  current fetch address (registered).
IFID_Instruction  output  32  fetched instruction; feeds the Controller's Instruction input.
IFID_PCPlus4  output  32  fetch address + 4 of the instruction held in IF/ID.
IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Memory read is combinational: word index = PC[ADDR_W+1:2]. Higher PC bits are ignored, so the index wraps modulo MEM_DEPTH (e.g. with depth 128, PC 0x200 reads word 0).
- Memory write is synchronous on Clk when ImemWe=1.
  - Writes are honoured even while Reset=1, so the program can be preloaded during reset.
  - Memory contents are never cleared by Reset.
- Read-during-write at the same index: IF/ID captures the old word; the new word is visible from the next cycle.
- Per rising edge, highest priority first:
  1. Reset=1: PC<=RESET_PC, IFID_Instruction<=0, IFID_PCPlus4<=0, IFID_Valid<=0.
  2. BranchTaken=1: PC<={BranchTarget[31:2],2'b00}, IFID_Instruction<=0, IFID_PCPlus4<=0, IFID_Valid<=0. Applies even if Stall=1 in the same cycle.
  3. Stall=1: PC, IFID_Instruction, IFID_PCPlus4 and IFID_Valid all hold.
  4. Otherwise: IFID_Instruction<=mem[PC index], IFID_PCPlus4<=PC+4, IFID_Valid<=1, PC<=PC+4.
- Fetch latency: an instruction at address A appears on IFID_Instruction one edge after PC==A with no stall.
- Bubble encoding is 32'h00000000 (MIPS sll NOP). The Controller decodes it as MemRead=0, MemWrite=0.
- PC arithmetic is 32-bit modular: 0xFFFFFFFC + 4 = 0x00000000. No overflow flag.
- Reset mid-operation discards the in-flight IF/ID instruction and restarts fetch at RESET_PC on the next non-reset edge.
- The PC is always word-aligned; bits [1:0] are 0 at all times after the first reset.
- No combinational path from any input to any output.
- All outputs are X until the first reset edge.

Test Plan:
- Preload while Reset=1: mem[0..3]=0x00000001, 0x8C080004, 0x20090005, 0xAC090008. Deassert Reset.
  - Edge 1: IFID_Instruction=0x00000001, IFID_PCPlus4=4, IFID_Valid=1, PC=4.
  - Edges 2-4 stream the next words, with IFID_PCPlus4=8, 0xC, 0x10.
- With PC=0x8, assert Stall for 3 edges: PC stays 0x8 and IF/ID stays {0x8C080004, 8, 1}. Release: the next edge gives IFID_Instruction=0x20090005 and PC=0xC.
- With PC=0xC, assert BranchTaken with BranchTarget=0x00000012: PC=0x10, IFID_Instruction=0, IFID_Valid=0. The next edge delivers mem[4] with IFID_PCPlus4=0x14.
- Assert Stall=1 and BranchTaken=1 (BranchTarget=0x40) together: PC=0x40 and IF/ID is a bubble; the redirect wins.
- With PC=0x14, write 0xDEADBEEF to index 5 in the same cycle: IF/ID captures the old mem[5]. Redirect to 0x14: the following fetch returns 0xDEADBEEF.
- Run to PC=0x20, then pulse Reset for one edge: PC=0, IFID_Valid=0. The next edge refetches 0x00000001 (memory retained).
- Redirect to 0x1FC (depth 128): fetches word 127, then PC=0x200 fetches word 0 (index wrap).
